// File: rtl/ifmap_index_sequencer_pkg.sv
// Shared types and widths for the ifmap index sequencer: FSM state, latched
// configuration and the row-counter width helper.
package ifmap_seq_pkg;

  localparam int IMG_W = 3;
  localparam int H_W   = 8;
  localparam int W_W   = 8;
  localparam int Q_W   = 3;
  localparam int RS_W  = 2;
  localparam int CH_W  = 10;
  localparam int E_W   = 8;
  localparam int R_W   = 4;
  localparam int U_W   = 3;
  localparam int PAD_W = 4;

  // Row extent (e-1)*U + R, plus room for two pad borders, must fit here.
  function automatic int d_width(input int h_w, input int e_w, input int u_w);
    return ((h_w > e_w + u_w) ? h_w : e_w + u_w) + 1;
  endfunction

  localparam int D_W  = d_width(H_W, E_W, U_W);
  localparam int WC_W = W_W + 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  typedef struct packed {
    logic [IMG_W-1:0] ifmap_base;
    logic [CH_W-1:0]  channel_base;
    logic [IMG_W-1:0] n;
    logic [H_W-1:0]   h;
    logic [W_W-1:0]   w;
    logic [Q_W-1:0]   q;
    logic [RS_W-1:0]  r;
    logic [E_W-1:0]   e;
    logic [R_W-1:0]   rf;
    logic [U_W-1:0]   u;
    logic [PAD_W-1:0] pad;
  } cfg_t;

endpackage

// File: rtl/ifmap_index_sequencer_wrap_counter.sv
// Wrapping loop counter; wrap is a same-cycle carry so counters can be chained.
module wrap_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             inc,
  input  logic [WIDTH-1:0] max,
  output logic [WIDTH-1:0] cnt,
  output logic             wrap
);

  assign wrap = inc & (cnt == max);

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= wrap ? '0 : cnt + WIDTH'(1);
    end
  end

endmodule

// File: rtl/ifmap_index_sequencer.sv
// Ifmap index sequencer: walks n -> w -> q -> d -> r and streams tuples over valid/ready.
// Optional build macro IFMAP_PAD_EN adds the pad port and border-padding region.
module ifmap_index_sequencer
  import ifmap_seq_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [IMG_W-1:0]  ifmap_base,
  input  logic [CH_W-1:0]   channel_base,
  input  logic [IMG_W-1:0]  n,
  input  logic [H_W-1:0]    H,
  input  logic [W_W-1:0]    W,
  input  logic [Q_W-1:0]    q,
  input  logic [RS_W-1:0]   r,
  input  logic [E_W-1:0]    e,
  input  logic [R_W-1:0]    R,
  input  logic [U_W-1:0]    U,
`ifdef IFMAP_PAD_EN
  input  logic [PAD_W-1:0]  pad,
`endif
  output logic              busy,
  output logic              done,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [IMG_W-1:0]  ifmap_index,
  output logic [CH_W-1:0]   channel_index,
  output logic [H_W-1:0]    row_index,
  output logic [W_W-1:0]    col_index,
  output logic              out_pad
);

  state_t           state;
  cfg_t             cfg;
  logic             accept, clr, zero_in;
  logic [RS_W-1:0]  r_cnt, r_max;
  logic [D_W-1:0]   d_cnt, d_max, d_len;
  logic [Q_W-1:0]   q_cnt, q_max;
  logic [WC_W-1:0]  w_cnt, w_max, w_len;
  logic [IMG_W-1:0] n_cnt, n_max;
  logic             r_wrap, d_wrap, q_wrap, w_wrap, n_wrap;

  assign accept  = out_valid & out_ready;
  assign clr     = abort | ((state == IDLE) & start);
  assign zero_in = (n == '0) | (W == '0) | (q == '0) | (r == '0) | (e == '0) | (R == '0);

  // pad is latched as zero in unpadded builds, so the extents collapse to D and W.
  assign d_len = (D_W'(cfg.e) - D_W'(1)) * D_W'(cfg.u) + D_W'(cfg.rf) + D_W'({cfg.pad, 1'b0});
  assign w_len = WC_W'(cfg.w) + WC_W'({cfg.pad, 1'b0});
  assign r_max = cfg.r - RS_W'(1);
  assign d_max = d_len - D_W'(1);
  assign q_max = cfg.q - Q_W'(1);
  assign w_max = w_len - WC_W'(1);
  assign n_max = cfg.n - IMG_W'(1);

  wrap_counter #(.WIDTH(RS_W)) u_r_cnt (
    .clk(clk), .reset(reset), .clr(clr), .inc(accept), .max(r_max), .cnt(r_cnt), .wrap(r_wrap)
  );
  wrap_counter #(.WIDTH(D_W)) u_d_cnt (
    .clk(clk), .reset(reset), .clr(clr), .inc(r_wrap), .max(d_max), .cnt(d_cnt), .wrap(d_wrap)
  );
  wrap_counter #(.WIDTH(Q_W)) u_q_cnt (
    .clk(clk), .reset(reset), .clr(clr), .inc(d_wrap), .max(q_max), .cnt(q_cnt), .wrap(q_wrap)
  );
  wrap_counter #(.WIDTH(WC_W)) u_w_cnt (
    .clk(clk), .reset(reset), .clr(clr), .inc(q_wrap), .max(w_max), .cnt(w_cnt), .wrap(w_wrap)
  );
  wrap_counter #(.WIDTH(IMG_W)) u_n_cnt (
    .clk(clk), .reset(reset), .clr(clr), .inc(w_wrap), .max(n_max), .cnt(n_cnt), .wrap(n_wrap)
  );

  // A zero-bound launch sits in DONE one cycle with done low, then pulses done.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cfg       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      out_valid <= 1'b0;
    end else if (abort) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            cfg.ifmap_base   <= ifmap_base;
            cfg.channel_base <= channel_base;
            cfg.n            <= n;
            cfg.h            <= H;
            cfg.w            <= W;
            cfg.q            <= q;
            cfg.r            <= r;
            cfg.e            <= e;
            cfg.rf           <= R;
            cfg.u            <= U;
`ifdef IFMAP_PAD_EN
            cfg.pad          <= pad;
`else
            cfg.pad          <= '0;
`endif
            busy <= 1'b1;
            if (zero_in) begin
              state <= DONE;
            end else begin
              state     <= RUN;
              out_valid <= 1'b1;
            end
          end
        end
        RUN: begin
          if (n_wrap) begin
            state     <= DONE;
            out_valid <= 1'b0;
            done      <= 1'b1;
          end
        end
        DONE: begin
          if (done) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
          end else begin
            done <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign ifmap_index   = cfg.ifmap_base + n_cnt;
  assign channel_index = cfg.channel_base + CH_W'(q_cnt) + CH_W'(r_cnt) * CH_W'(cfg.q);

`ifdef IFMAP_PAD_EN
  localparam int DS_W = D_W + 1;
  localparam int CS_W = WC_W + 1;
  logic signed [DS_W-1:0] row_s;
  logic signed [CS_W-1:0] col_s;
  logic                   in_pad;

  // Signed positions relative to the unpadded image; anything outside is border.
  assign row_s  = $signed({1'b0, d_cnt}) - $signed(DS_W'(cfg.pad));
  assign col_s  = $signed({1'b0, w_cnt}) - $signed(CS_W'(cfg.pad));
  assign in_pad = row_s[DS_W-1] | (row_s >= $signed(DS_W'(cfg.h))) |
                  col_s[CS_W-1] | (col_s >= $signed(CS_W'(cfg.w)));
  assign out_pad   = in_pad & (state == RUN);
  assign row_index = in_pad ? '0 : row_s[H_W-1:0];
  assign col_index = in_pad ? '0 : col_s[W_W-1:0];
`else
  logic unused_bits;
  assign out_pad     = 1'b0;
  assign row_index   = d_cnt[H_W-1:0];
  assign col_index   = w_cnt[W_W-1:0];
  assign unused_bits = ^{d_cnt[D_W-1:H_W], w_cnt[WC_W-1:W_W], cfg.h, cfg.pad};
`endif

endmodule
